// File: rtl/tap_controller_if.sv
// Pin-side bundle of the TAP controller: TMS/instruction in, scan strobes out.
// CNT_W must match the CNT_W of the tap_controller it is bound to.
interface tap_controller_if #(
    parameter int CNT_W = 8
);
    logic             tms;
    logic [1:0]       inst;
    logic             capture_dr;
    logic             shift_dr;
    logic             update_dr;
    logic             capture_ir;
    logic             shift_ir;
    logic             update_ir;
    logic             select_ir;
    logic             tdo_en;
    logic             bs_en;
    logic             logic_reset;
    logic [CNT_W-1:0] shift_count;

    // master drives the pins (chip top / bench), slave is the controller
    modport master (
        output tms, inst,
        input  capture_dr, shift_dr, update_dr,
        input  capture_ir, shift_ir, update_ir,
        input  select_ir, tdo_en, bs_en, logic_reset, shift_count
    );

    modport slave (
        input  tms, inst,
        output capture_dr, shift_dr, update_dr,
        output capture_ir, shift_ir, update_ir,
        output select_ir, tdo_en, bs_en, logic_reset, shift_count
    );
endinterface

// File: rtl/tap_controller.sv
// 16-state JTAG TAP controller. Sequences the boundary-scan DR chain and the
// 2-bit IR with Moore strobes decoded from the registered state, tracks the
// number of shift cycles (saturating) and drives bs_en for EXTEST.
// Optional build macro TAP_STATE_OUT_EN exposes the raw state code as
// output port tap_state[3:0].
module tap_controller #(
    parameter int         CNT_W     = 8,
    parameter logic [1:0] EXTEST_OP = 2'b00
) (
    input  logic             TCK,
    input  logic             TRST_N,
    tap_controller_if.slave  bus
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0]       tap_state
`endif
);

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SEL_DR  = 4'h7,
        CAP_DR  = 4'h6,
        SH_DR   = 4'h2,
        EX1_DR  = 4'h1,
        PAU_DR  = 4'h3,
        EX2_DR  = 4'h0,
        UPD_DR  = 4'h5,
        SEL_IR  = 4'h4,
        CAP_IR  = 4'hE,
        SH_IR   = 4'hA,
        EX1_IR  = 4'h9,
        PAU_IR  = 4'hB,
        EX2_IR  = 4'h8,
        UPD_IR  = 4'hD
    } tap_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tap_state_e       state;
    tap_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             bs_en_q;
    logic             upd_ir_d;

    // State register; async reset parks the TAP in Test-Logic-Reset
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) state <= TLR;
        else         state <= state_nxt;
    end

    // Next-state decode from TMS
    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:    state_nxt = bus.tms ? TLR    : RTI;
            RTI:    state_nxt = bus.tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = bus.tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = bus.tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = bus.tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = bus.tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = bus.tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = bus.tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = bus.tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = bus.tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = bus.tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = bus.tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = bus.tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = bus.tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = bus.tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = bus.tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // Moore strobes and selects decoded from the registered state
    always_comb begin
        bus.capture_dr  = (state == CAP_DR);
        bus.shift_dr    = (state == SH_DR);
        bus.update_dr   = (state == UPD_DR);
        bus.capture_ir  = (state == CAP_IR);
        bus.shift_ir    = (state == SH_IR);
        bus.update_ir   = (state == UPD_IR);
        bus.tdo_en      = (state == SH_DR) || (state == SH_IR);
        bus.logic_reset = (state == TLR);
        bus.select_ir   = (state == SEL_IR) || (state == CAP_IR) ||
                          (state == SH_IR)  || (state == EX1_IR) ||
                          (state == PAU_IR) || (state == EX2_IR) ||
                          (state == UPD_IR);
        bus.bs_en       = bs_en_q;
        bus.shift_count = cnt;
    end

    // Shift-cycle counter: zeroed entering Capture, counts Shift cycles,
    // sticks at all-ones, holds through Exit/Pause so a resumed shift continues
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            cnt <= '0;
        end else if (state_nxt == CAP_DR || state_nxt == CAP_IR) begin
            cnt <= '0;
        end else if ((state == SH_DR || state == SH_IR) && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // bs_en samples the decoded instruction one edge after Update-IR so the
    // IR update flops have settled; dropped whenever the TAP sits in TLR
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            upd_ir_d <= 1'b0;
            bs_en_q  <= 1'b0;
        end else begin
            upd_ir_d <= (state == UPD_IR);
            if (upd_ir_d)          bs_en_q <= (bus.inst == EXTEST_OP);
            else if (state == TLR) bs_en_q <= 1'b0;
        end
    end

`ifdef TAP_STATE_OUT_EN
    // Raw state code for debug visibility
    assign tap_state = state;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: table-driven behavioural TAP model checked on
// every falling TCK, directed scans with literal expectations, then random TMS.
module tb_tap_controller;

    logic TCK    = 1'b0;
    logic TRST_N = 1'b1;

    tap_controller_if #(.CNT_W(8)) bus ();
    tap_controller_if #(.CNT_W(2)) bus2 ();

    assign bus2.tms  = bus.tms;
    assign bus2.inst = bus.inst;

`ifdef TAP_STATE_OUT_EN
    logic [3:0] tap_state;
    logic [3:0] tap_state2;
`endif

    tap_controller #(.CNT_W(8), .EXTEST_OP(2'b00)) dut (
        .TCK(TCK), .TRST_N(TRST_N), .bus(bus)
`ifdef TAP_STATE_OUT_EN
        , .tap_state(tap_state)
`endif
    );

    tap_controller #(.CNT_W(2), .EXTEST_OP(2'b00)) dut2 (
        .TCK(TCK), .TRST_N(TRST_N), .bus(bus2)
`ifdef TAP_STATE_OUT_EN
        , .tap_state(tap_state2)
`endif
    );

    always #5 TCK = ~TCK;

    // Model states in natural 1149.1 order:
    // 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
    // 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
    int nx0  [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1  [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int code [16] = '{15, 12, 7, 6, 2, 1, 3, 0, 5, 4, 14, 10, 9, 11, 8, 13};

    int m_st   = 0;
    int m_raw  = 0;
    bit m_pend = 1'b0;
    bit m_bs   = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    int n_cap, n_sh, n_upd, n_sel;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural model: table walk, unbounded shift tally, delayed bs_en load
    always @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            m_st   <= 0;
            m_raw  <= 0;
            m_pend <= 1'b0;
            m_bs   <= 1'b0;
        end else begin
            m_st <= bus.tms ? nx1[m_st] : nx0[m_st];
            if ((bus.tms ? nx1[m_st] : nx0[m_st]) inside {3, 10}) m_raw <= 0;
            else if (m_st inside {4, 11})                          m_raw <= m_raw + 1;
            m_pend <= (m_st == 15);
            if (m_pend)         m_bs <= (bus.inst == 2'b00);
            else if (m_st == 0) m_bs <= 1'b0;
        end
    end

    // Compare every falling edge once the bench has applied reset
    always @(negedge TCK) begin
        if (cmp_on) begin
            chk("capture_dr",  int'(bus.capture_dr),  int'(m_st == 3));
            chk("shift_dr",    int'(bus.shift_dr),    int'(m_st == 4));
            chk("update_dr",   int'(bus.update_dr),   int'(m_st == 8));
            chk("capture_ir",  int'(bus.capture_ir),  int'(m_st == 10));
            chk("shift_ir",    int'(bus.shift_ir),    int'(m_st == 11));
            chk("update_ir",   int'(bus.update_ir),   int'(m_st == 15));
            chk("select_ir",   int'(bus.select_ir),   int'(m_st >= 9));
            chk("tdo_en",      int'(bus.tdo_en),      int'(m_st == 4 || m_st == 11));
            chk("logic_reset", int'(bus.logic_reset), int'(m_st == 0));
            chk("bs_en",       int'(bus.bs_en),       int'(m_bs));
            chk("shift_count", int'(bus.shift_count), clamp(m_raw, 255));
            chk("shift_count_w2", int'(bus2.shift_count), clamp(m_raw, 3));
`ifdef TAP_STATE_OUT_EN
            chk("tap_state",   int'(tap_state),       code[m_st]);
`endif
        end
    end

    task automatic clr();
        n_cap = 0; n_sh = 0; n_upd = 0; n_sel = 0;
    endtask

    task automatic step(input bit t);
        @(negedge TCK);
        bus.tms = t;
        @(posedge TCK);
        #1;
        if (bus.capture_dr) n_cap++;
        if (bus.shift_dr)   n_sh++;
        if (bus.update_dr)  n_upd++;
        if (bus.select_ir)  n_sel++;
    endtask

    task automatic steps(input bit t, input int n);
        for (int i = 0; i < n; i++) step(t);
    endtask

    initial begin
        bus.tms  = 1'b1;
        bus.inst = 2'b11;
        clr();
        #1 TRST_N = 1'b0;
        cmp_on = 1'b1;
        #2;
        chk("rst_logic_reset", int'(bus.logic_reset), 1);
        chk("rst_shift_count", int'(bus.shift_count), 0);
        chk("rst_bs_en",       int'(bus.bs_en), 0);
        chk("rst_select_ir",   int'(bus.select_ir), 0);
        @(negedge TCK); @(negedge TCK);
        #2 TRST_N = 1'b1;

        // T2: five TMS=1 edges from RTI and from Shift-IR
        step(0);
        chk("t2_rti", int'(bus.logic_reset), 0);
        steps(1, 5);
        chk("t2_tlr_from_rti", int'(bus.logic_reset), 1);
        step(0); step(1); step(1); step(0); step(0);
        chk("t2_in_shir", int'(bus.shift_ir), 1);
        steps(1, 4);
        chk("t2_not_yet_tlr", int'(bus.logic_reset), 0);
        step(1);
        chk("t2_tlr_from_shir", int'(bus.logic_reset), 1);

        // T3: DR scan of 5 shift cycles
        step(0);
        clr();
        step(1); step(0); step(0);
        steps(0, 4);
        step(1); step(1); step(0);
        chk("t3_capture_cycles", n_cap, 1);
        chk("t3_shift_cycles",   n_sh, 5);
        chk("t3_update_cycles",  n_upd, 1);
        chk("t3_shift_count",    int'(bus.shift_count), 5);
        chk("t3_select_ir",      n_sel, 0);
        chk("t3_rti_idle",       int'(bus.logic_reset | bus.tdo_en | bus.update_dr), 0);

        // T4: IR scan loading EXTEST, then TLR clears bs_en
        bus.inst = 2'b00;
        clr();
        step(1); step(1); step(0); step(0); step(0); step(1); step(1);
        chk("t4_update_ir", int'(bus.update_ir), 1);
        chk("t4_select_ir_cycles", n_sel, 6);
        chk("t4_bs_en_not_yet", int'(bus.bs_en), 0);
        step(0);
        chk("t4_bs_en_pending", int'(bus.bs_en), 0);
        step(0);
        chk("t4_bs_en_set", int'(bus.bs_en), 1);
        step(1); step(1); step(1);
        chk("t4_tlr", int'(bus.logic_reset), 1);
        step(0);
        chk("t4_bs_en_cleared", int'(bus.bs_en), 0);

        // T5: shift interrupted by pause, then resumed
        clr();
        step(1); step(0); step(0); step(0); step(0);
        step(1); step(0); step(0); step(1); step(0); step(0);
        chk("t5_no_update_yet", n_upd, 0);
        step(1);
        chk("t5_shift_count", int'(bus.shift_count), 5);
        step(1);
        chk("t5_update_dr", int'(bus.update_dr), 1);
        step(0);

        // T6: narrow counter saturates, wide one keeps counting
        step(1); step(0); step(0);
        steps(0, 5);
        step(1);
        chk("t6_sat_w2", int'(bus2.shift_count), 3);
        chk("t6_w8",     int'(bus.shift_count), 6);
        step(1); step(0);

        // T1: reset mid Shift-DR takes effect immediately, no update strobe
        step(1); step(0); step(0); step(0);
        chk("t1_in_shdr", int'(bus.shift_dr), 1);
        #2 TRST_N = 1'b0;
        #1;
        chk("t1_shift_dr",    int'(bus.shift_dr), 0);
        chk("t1_logic_reset", int'(bus.logic_reset), 1);
        chk("t1_update_dr",   int'(bus.update_dr), 0);
        chk("t1_count",       int'(bus.shift_count), 0);
        @(negedge TCK);
        #2 TRST_N = 1'b1;

        // Random TMS / instruction traffic with occasional async reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.inst = 2'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 199) == 0) begin
                #2 TRST_N = 1'b0;
                #1 TRST_N = 1'b1;
            end
        end

        @(negedge TCK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
